// File: rtl/distribution_load_unit_pkg.sv
// Shared definitions for the distribution load unit.
//   - Default record/word/slot/timeout constants used as parameter defaults.
//   - FSM state encoding shared by the top-level and any tooling that decodes it.
package distribution_load_unit_pkg;

  localparam int unsigned DU_DIST_W    = 256;
  localparam int unsigned DU_WORD_W    = 32;
  localparam int unsigned DU_SLOT_BITS = 2;
  localparam int unsigned DU_TIMEOUT   = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    DATA_OUT = 2'd2
  } du_state_e;

endpackage

// File: rtl/distribution_load_unit_beat_timer.sv
// du_beat_timer: per-beat wait counter with timeout compare.
//   clk      in  clock
//   rst      in  asynchronous active-high reset
//   clear    in  restart the count (load start or completed beat)
//   count_en in  count one waiting cycle
//   expired  out count has reached TIMEOUT (never asserted when TIMEOUT=0)
module du_beat_timer
  import distribution_load_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = DU_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt;

  // Saturates at TIMEOUT so the compare stays asserted until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    expired = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
  end

endmodule

// File: rtl/distribution_load_unit.sv
// distribution_load_unit: fetches one DIST_W-bit distribution record from a
// word-wide source, MSW first, and presents it on DU_result.
//   clk          in  clock
//   rst          in  asynchronous active-high reset
//   DUCtrl       in  load command, sampled only in IDLE
//   rs1          in  operand; low SLOT_BITS select the slot
//   src_req      out word read request
//   src_addr     out {slot, beat index}
//   src_ack      in  source accepted request; src_data valid this cycle
//   src_data     in  returned word
//   DU_result    out last completed distribution
//   du_clk_stall out pipeline stall while a load is in progress
//   du_err       out sticky: last load timed out
module distribution_load_unit
  import distribution_load_unit_pkg::*;
#(
  parameter  int unsigned DIST_W    = DU_DIST_W,
  parameter  int unsigned WORD_W    = DU_WORD_W,
  parameter  int unsigned SLOT_BITS = DU_SLOT_BITS,
  parameter  int unsigned TIMEOUT   = DU_TIMEOUT,
  localparam int unsigned BEATS     = DIST_W / WORD_W,
  localparam int unsigned BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned ADDR_W    = SLOT_BITS + BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DUCtrl,
  input  logic [31:0]       rs1,
  output logic              src_req,
  output logic [ADDR_W-1:0] src_addr,
  input  logic              src_ack,
  input  logic [WORD_W-1:0] src_data,
  output logic [DIST_W-1:0] DU_result,
  output logic              du_clk_stall,
  output logic              du_err
);

  du_state_e            state_q, state_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 req_d;
  logic [DIST_W-1:0]    buf_q, buf_d;
  logic [DIST_W-1:0]    result_d;
  logic                 stall_d, err_d;

  logic beat_done, last_beat, start, timed_out;
  logic unused_rs1;

  assign unused_rs1 = ^rs1[31:SLOT_BITS];

  assign start     = (state_q == IDLE) && DUCtrl;
  assign beat_done = (state_q == FETCH) && src_req && src_ack;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign src_addr  = {slot_q, beat_q};

  du_beat_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (start || beat_done),
    .count_en ((state_q == FETCH) && !beat_done),
    .expired  (timed_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      beat_q       <= '0;
      src_req      <= 1'b0;
      buf_q        <= '0;
      DU_result    <= '0;
      du_clk_stall <= 1'b0;
      du_err       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      beat_q       <= beat_d;
      src_req      <= req_d;
      buf_q        <= buf_d;
      DU_result    <= result_d;
      du_clk_stall <= stall_d;
      du_err       <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    beat_d   = beat_q;
    req_d    = src_req;
    buf_d    = buf_q;
    result_d = DU_result;
    stall_d  = du_clk_stall;
    err_d    = du_err;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (DUCtrl) begin
          slot_d  = rs1[SLOT_BITS-1:0];
          beat_d  = '0;
          stall_d = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // src_req is registered: it rises one cycle into FETCH and stays up
        // across beats; an ack in the same cycle as expiry still wins.
        req_d = 1'b1;
        if (beat_done) begin
          buf_d[DIST_W - 1 - int'(beat_q) * WORD_W -: WORD_W] = src_data;
          if (last_beat) begin
            req_d   = 1'b0;
            state_d = DATA_OUT;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (timed_out) begin
          req_d    = 1'b0;
          result_d = '0;
          err_d    = 1'b1;
          stall_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      DATA_OUT: begin
        req_d    = 1'b0;
        result_d = buf_q;
        err_d    = 1'b0;
        stall_d  = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        stall_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_distribution_load_unit.sv
module tb_distribution_load_unit;

  logic         clk;
  logic         rst;
  logic         DUCtrl;
  logic [31:0]  rs1;
  logic         src_req;
  logic [4:0]   src_addr;
  logic         src_ack;
  logic [31:0]  src_data;
  logic [255:0] DU_result;
  logic         du_clk_stall;
  logic         du_err;

  logic         s_ctrl;
  logic [31:0]  s_rs1;
  logic         s_req;
  logic [2:0]   s_addr;
  logic         s_ack;
  logic [15:0]  s_data;
  logic [63:0]  s_result;
  logic         s_stall;
  logic         s_err;

  logic [31:0]  mem   [0:31];
  logic [15:0]  s_mem [0:7];

  int           total = 0;
  int           bad   = 0;
  int           ack_mode = 0;   // 0: always ack, 1: random gaps, 2: never ack
  logic [4:0]   addr_log [$];

  assign src_data = mem[src_addr];
  assign s_data   = s_mem[s_addr];

  distribution_load_unit u_dut (
    .clk          (clk),
    .rst          (rst),
    .DUCtrl       (DUCtrl),
    .rs1          (rs1),
    .src_req      (src_req),
    .src_addr     (src_addr),
    .src_ack      (src_ack),
    .src_data     (src_data),
    .DU_result    (DU_result),
    .du_clk_stall (du_clk_stall),
    .du_err       (du_err)
  );

  distribution_load_unit #(
    .DIST_W    (64),
    .WORD_W    (16),
    .SLOT_BITS (1)
  ) u_dut_small (
    .clk          (clk),
    .rst          (rst),
    .DUCtrl       (s_ctrl),
    .rs1          (s_rs1),
    .src_req      (s_req),
    .src_addr     (s_addr),
    .src_ack      (s_ack),
    .src_data     (s_data),
    .DU_result    (s_result),
    .du_clk_stall (s_stall),
    .du_err       (s_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: record is the slot's words concatenated, first word most significant.
  function automatic logic [255:0] build_exp(input int slot);
    logic [255:0] e = '0;
    for (int b = 0; b < 8; b++) e = (e << 32) | 256'(mem[slot * 8 + b]);
    return e;
  endfunction

  // Source responder and address monitor.
  initial begin
    int         gap = 0;
    logic       prev_req = 1'b0;
    logic       prev_ack = 1'b0;
    logic [4:0] prev_addr = '0;
    src_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_req && !prev_ack && src_req) chk("addr_stable", 256'(src_addr), 256'(prev_addr));
      case (ack_mode)
        0: src_ack = 1'b1;
        2: src_ack = 1'b0;
        default: begin
          if (src_ack) gap = $urandom_range(0, 5);
          else if (gap > 0 && src_req) gap--;
          src_ack = src_req && (gap == 0);
        end
      endcase
      if (src_req && src_ack) addr_log.push_back(src_addr);
      prev_req  = src_req;
      prev_ack  = src_ack;
      prev_addr = src_addr;
    end
  end

  task automatic run_load(input int slot, input bit hold, output int cycles);
    addr_log.delete();
    @(negedge clk);
    rs1      = $urandom;
    rs1[1:0] = 2'(slot);
    DUCtrl   = 1'b1;
    @(negedge clk);
    if (!hold) DUCtrl = 1'b0;
    cycles = 0;
    while (du_clk_stall && cycles < 2000) begin
      cycles++;
      @(negedge clk);
    end
    DUCtrl = 1'b0;
  endtask

  task automatic check_good_load(input string tag, input int slot);
    chk({tag, "_result"}, DU_result, build_exp(slot));
    chk({tag, "_err"}, 256'(du_err), 256'(0));
    chk({tag, "_req_low"}, 256'(src_req), 256'(0));
    chk({tag, "_beats"}, 256'(addr_log.size()), 256'(8));
    for (int b = 0; b < addr_log.size() && b < 8; b++)
      chk({tag, "_addr"}, 256'(addr_log[b]), 256'(slot * 8 + b));
  endtask

  initial begin
    logic [255:0] ref_rec;
    logic [63:0]  s_exp;
    int           cyc;
    int           busy;
    int           slot;

    rst = 1'b1; DUCtrl = 1'b0; rs1 = '0;
    s_ctrl = 1'b0; s_rs1 = '0; s_ack = 1'b1;
    ref_rec = 256'h000200140024000400502208111C12C0DC02A009001000000000000000000000;
    for (int a = 0; a < 32; a++) mem[a] = $urandom;
    for (int b = 0; b < 8; b++) mem[16 + b] = ref_rec[255 - b * 32 -: 32];
    for (int a = 0; a < 8; a++) s_mem[a] = 16'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_result", DU_result, 256'(0));
    chk("rst_req", 256'(src_req), 256'(0));
    chk("rst_addr", 256'(src_addr), 256'(0));
    chk("rst_stall", 256'(du_clk_stall), 256'(0));
    chk("rst_err", 256'(du_err), 256'(0));
    rst = 1'b0;

    // Known record from slot 2 with ack held high: 10-cycle stall
    ack_mode = 0;
    run_load(2, 1'b0, cyc);
    chk("known_stall_cycles", 256'(cyc), 256'(10));
    chk("known_value", DU_result, ref_rec);
    check_good_load("known", 2);

    // Random ack gaps
    ack_mode = 1;
    for (int i = 0; i < 6; i++) begin
      slot = $urandom_range(0, 3);
      run_load(slot, 1'b0, cyc);
      check_good_load("gaps", slot);
    end

    // Timeout: no ack ever
    ack_mode = 2;
    run_load(0, 1'b0, cyc);
    chk("to_stall_cycles", 256'(cyc), 256'(256));
    chk("to_err", 256'(du_err), 256'(1));
    chk("to_result", DU_result, 256'(0));
    chk("to_req", 256'(src_req), 256'(0));
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 256'(du_err), 256'(1));

    // DUCtrl held through FETCH and the DATA_OUT edge: single load only
    ack_mode = 0;
    run_load(3, 1'b1, cyc);
    chk("ign_stall_cycles", 256'(cyc), 256'(10));
    check_good_load("ign", 3);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (src_req || du_clk_stall) busy++;
    end
    chk("ign_no_second_load", 256'(busy), 256'(0));

    // Reset in the middle of a load at beat 4
    @(negedge clk);
    rs1 = 32'h3; DUCtrl = 1'b1;
    @(negedge clk);
    DUCtrl = 1'b0;
    cyc = 0;
    while (!(src_req && src_addr[2:0] == 3'd4) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_reach_beat4", 256'(cyc < 100), 256'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_result", DU_result, 256'(0));
    chk("mid_rst_req", 256'(src_req), 256'(0));
    chk("mid_rst_addr", 256'(src_addr), 256'(0));
    chk("mid_rst_stall", 256'(du_clk_stall), 256'(0));
    chk("mid_rst_err", 256'(du_err), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    run_load(1, 1'b0, cyc);
    chk("post_rst_stall_cycles", 256'(cyc), 256'(10));
    check_good_load("post_rst", 1);

    // Narrow configuration: 4 beats of 16 bits, slot 1
    s_exp = '0;
    for (int b = 0; b < 4; b++) s_exp = (s_exp << 16) | 64'(s_mem[4 + b]);
    @(negedge clk);
    s_rs1 = 32'hFFFF_FFF1; s_ctrl = 1'b1;
    @(negedge clk);
    s_ctrl = 1'b0;
    cyc = 0;
    while (s_stall && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("small_stall_cycles", 256'(cyc), 256'(6));
    chk("small_result", 256'(s_result), 256'(s_exp));
    chk("small_err", 256'(s_err), 256'(0));
    chk("small_req", 256'(s_req), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/distribution_load_unit.md
DISTRIBUTION_LOAD_UNIT -- requirements
Module: distribution_load_unit

Interface
REQ-001 Parameter DIST_W, default 256: width of one distribution record in bits.
REQ-002 Parameter WORD_W, default 32: source word width; DIST_W SHALL be an integer multiple of WORD_W; BEATS = DIST_W/WORD_W.
REQ-003 Parameter SLOT_BITS, default 2: log2 of the number of distribution slots held by the source.
REQ-004 Parameter TIMEOUT, default 255: maximum cycles waited per beat for src_ack; 0 disables the timeout.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock; all state changes on the rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 DUCtrl  in  1  load command, sampled only in IDLE.
REQ-009 rs1  in  32  operand; rs1[SLOT_BITS-1:0] selects the slot.
REQ-010 src_req  out  1  word read request to the sensor/SPI source.
REQ-011 src_addr  out  SLOT_BITS+log2(BEATS)  {slot, beat index}.
REQ-012 src_ack  in  1  source accepts the request; src_data is valid in the same cycle.
REQ-013 src_data  in  WORD_W  returned word.
REQ-014 DU_result  out  DIST_W  last completed distribution.
REQ-015 du_clk_stall  out  1  pipeline stall while a load is in progress.
REQ-016 du_err  out  1  sticky flag: the last load timed out.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, DATA_OUT.
REQ-018 IDLE: when DUCtrl=1, latch slot from rs1, clear the beat counter and wait counter, set du_clk_stall=1, and go to FETCH on the same edge.
REQ-019 FETCH: src_req=1 and src_addr={slot, beat}; a beat completes on an edge where src_req&src_ack=1.
REQ-020 On a beat completion, src_data SHALL be written to buffer bits [DIST_W-1-beat*WORD_W -: WORD_W], so beat 0 is the most significant word.
REQ-021 src_req SHALL stay high across back-to-back beats; src_addr SHALL only change after a completed beat.
REQ-022 Completion of beat BEATS-1 SHALL move the FSM to DATA_OUT and drop src_req on the same edge.
REQ-023 DATA_OUT: DU_result <= buffer, du_err <= 0, du_clk_stall <= 0, go to IDLE; DU_result changes only here or on timeout.
REQ-024 Latency with src_ack held high: DU_result updates and stall falls at edge BEATS+2 counted from the edge that sampled DUCtrl (edge 0).
REQ-025 Timeout: if TIMEOUT!=0 and the wait counter reaches TIMEOUT without an ack, drop src_req, set DU_result=0 and du_err=1, clear du_clk_stall, and go to IDLE; the counter restarts at each completed beat.
REQ-026 DUCtrl while not in IDLE SHALL be ignored, with no queueing.
REQ-027 DUCtrl asserted in the same cycle that DATA_OUT returns to IDLE SHALL NOT start a load; it is sampled again from the next cycle.
REQ-028 The beat counter SHALL never wrap past BEATS-1; rs1 bits above SLOT_BITS SHALL be ignored.
REQ-029 Illegal state encodings SHALL return to IDLE with src_req=0 and du_clk_stall=0.

Reset
REQ-030 On rst=1: state=IDLE, src_req=0, src_addr=0, DU_result=0, buffer=0, du_clk_stall=0, du_err=0, all counters=0.
REQ-031 Reset mid-load SHALL abort with no partial result visible; the first load after reset SHALL start from beat 0.

Structure
REQ-032 A shared package SHALL hold the state encodings and the default DIST_W, WORD_W, SLOT_BITS and TIMEOUT constants.
REQ-033 One sub-module, du_beat_timer (wait counter plus timeout compare), is natural; the rest SHALL be a single FSM module.

Verification
REQ-034 Defaults, src_ack tied to 1, slot 2 source returning words 0x000200140024000400502208111C12C0DC02A009001000000000000000000000 (MSW first) -> DU_result equals that value; stall high for exactly 10 cycles; src_addr runs 0x10..0x17.
REQ-035 Random src_ack gaps of 0-5 cycles -> correct assembled result; src_addr stable while src_req=1 and unacked.
REQ-036 src_ack never asserted, TIMEOUT=255 -> after 256 FETCH cycles: du_err=1, DU_result=0, stall=0, src_req=0.
REQ-037 DUCtrl pulsed during FETCH and on the DATA_OUT edge -> no second load and no src_req after completion.
REQ-038 rst pulsed at beat 4 -> all outputs 0; a following load of slot 1 returns the full slot-1 record.
REQ-039 DIST_W=64, WORD_W=16, SLOT_BITS=1 -> 4 beats, result assembled MSW first, latency 6 edges.
